// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// ALUOp classes and ALU operation codes.
package mc_controller_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEMADR   = 4'd2;
   localparam state_t S_MEMREAD  = 4'd3;
   localparam state_t S_MEMWB    = 4'd4;
   localparam state_t S_MEMWRITE = 4'd5;
   localparam state_t S_EXECR    = 4'd6;
   localparam state_t S_EXECI    = 4'd7;
   localparam state_t S_ALUWB    = 4'd8;
   localparam state_t S_BEQ      = 4'd9;
   localparam state_t S_JAL      = 4'd10;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b011;
   localparam logic [2:0] ALUC_SLT = 3'b101;

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   return 2'b01;
         OP_BEQ:  return 2'b10;
         OP_JAL:  return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the ALUOp class plus instruction fields to an ALU operation.
module aludec
   import mc_controller_pkg::*;
(
   input  logic       opb5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic [1:0] alu_op,
   output logic [2:0] alu_control
);

   logic r_sub;

   // Only R-type (op[5]=1) with funct7b5 subtracts; addi ignores bit 30.
   assign r_sub = opb5 & funct7b5;

   always_comb begin
      alu_control = ALUC_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALUC_ADD;
         ALUOP_SUB: alu_control = ALUC_SUB;
         default: begin
            case (funct3)
               3'b000:  alu_control = r_sub ? ALUC_SUB : ALUC_ADD;
               3'b010:  alu_control = ALUC_SLT;
               3'b110:  alu_control = ALUC_OR;
               3'b111:  alu_control = ALUC_AND;
               default: alu_control = ALUC_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V controller: Moore FSM sequencing fetch, decode, memory,
// execute and writeback, plus the input-dependent ImmSrc/ALUControl/PCWrite.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 on MemReady
// DECODE   | compute branch/jump target into ALUOut
// MEMADR   | compute load/store address
// MEMREAD  | load access, wait for MemReady
// MEMWB    | write loaded data to register file
// MEMWRITE | store access, wait for MemReady
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to register file
// BEQ      | compare rs1/rs2, take branch on Zero
// JAL      | PC <- target, ALU computes return address
module mc_controller
   import mc_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl
);

   state_t     state;
   state_t     state_next;
   logic [1:0] alu_op;
   logic       mem_req;
   logic       ir_write;
   logic       pc_update;
   logic       reg_write;
   logic       mem_write;
   logic       branch;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:    if (MemReady) state_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECR;
               OP_I:         state_next = S_EXECI;
               OP_BEQ:       state_next = S_BEQ;
               OP_JAL:       state_next = S_JAL;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (MemReady) state_next = S_MEMWB;
         S_MEMWRITE: if (MemReady) state_next = S_FETCH;
         S_MEMWB:    state_next = S_FETCH;
         S_BEQ:      state_next = S_FETCH;
         S_EXECR:    state_next = S_ALUWB;
         S_EXECI:    state_next = S_ALUWB;
         S_JAL:      state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         default:    state_next = S_FETCH;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      ir_write  = 1'b0;
      pc_update = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      alu_op    = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_write  = MemReady;
            pc_update = MemReady;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_FUNC;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = ALUOP_FUNC;
         end
         S_ALUWB:  reg_write = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // Side-effecting strobes are held off for the whole reset cycle.
   assign MemReq   = mem_req & ~reset;
   assign IRWrite  = ir_write & ~reset;
   assign RegWrite = reg_write & ~reset;
   assign MemWrite = mem_write & ~reset;
   assign PCWrite  = ((branch & Zero) | pc_update) & ~reset;

   assign ImmSrc = imm_src_of(op);

   aludec u_aludec (
      .opb5        (op[5]),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_op      (alu_op),
      .alu_control (ALUControl)
   );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expected outputs are
// queued as stimulus is applied and compared on the falling edge.
module tb_mc_controller;

   localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
   localparam int ER = 6, EI = 7, AW = 8, BQ = 9, J = 10;

   localparam logic [6:0] C_LW  = 7'b0000011;
   localparam logic [6:0] C_SW  = 7'b0100011;
   localparam logic [6:0] C_R   = 7'b0110011;
   localparam logic [6:0] C_I   = 7'b0010011;
   localparam logic [6:0] C_BEQ = 7'b1100011;
   localparam logic [6:0] C_JAL = 7'b1101111;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;
   logic       MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0] ALUControl;

   logic [6:0] nxt_op;
   logic [2:0] nxt_funct3;
   logic       nxt_f7b5;

   logic [16:0] obs;
   logic [16:0] got;
   logic [16:0] exp;
   logic [16:0] scb[$];
   int checks;
   int errors;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .MemReq     (MemReq),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl)
   );

   assign obs = {MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected output vector for a given state and the inputs of that cycle.
   function automatic logic [16:0] model(input int st, input bit mr, input bit z, input bit rst);
      logic mreq, adr, irw, pcw, rw, mw;
      logic [1:0] sa, sbb, rs, aop, imm;
      logic [2:0] ac;
      mreq = 0; adr = 0; irw = 0; pcw = 0; rw = 0; mw = 0;
      sa = 2'b00; sbb = 2'b00; rs = 2'b00; aop = 2'b00;
      case (st)
         F:   begin mreq = 1; sbb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         D:   begin sa = 2'b01; sbb = 2'b01; end
         MA:  begin sa = 2'b10; sbb = 2'b01; end
         MR:  begin mreq = 1; adr = 1; end
         MWB: begin rs = 2'b01; rw = 1; end
         MW:  begin mreq = 1; adr = 1; mw = 1; end
         ER:  begin sa = 2'b10; aop = 2'b10; end
         EI:  begin sa = 2'b10; sbb = 2'b01; aop = 2'b10; end
         AW:  rw = 1;
         BQ:  begin sa = 2'b10; aop = 2'b01; pcw = z; end
         J:   begin sa = 2'b01; sbb = 2'b10; pcw = 1; end
         default: ;
      endcase
      if (op == C_SW)       imm = 2'b01;
      else if (op == C_BEQ) imm = 2'b10;
      else if (op == C_JAL) imm = 2'b11;
      else                  imm = 2'b00;
      if (aop == 2'b00)      ac = 3'b000;
      else if (aop == 2'b01) ac = 3'b001;
      else if (funct3 == 3'b000) ac = (op[5] && funct7b5) ? 3'b001 : 3'b000;
      else if (funct3 == 3'b010) ac = 3'b101;
      else if (funct3 == 3'b110) ac = 3'b011;
      else if (funct3 == 3'b111) ac = 3'b010;
      else ac = 3'b000;
      if (rst) begin mreq = 0; irw = 0; pcw = 0; rw = 0; mw = 0; end
      return {mreq, adr, irw, pcw, rw, mw, sa, sbb, rs, imm, ac};
   endfunction

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      nxt_op = o; nxt_funct3 = f3; nxt_f7b5 = f7;
   endtask

   // Advance one cycle: apply inputs after the rising edge, queue the
   // expected outputs, and return at the falling edge ready to sample.
   task automatic drive(input int st, input bit mr, input bit z, input bit rst);
      @(posedge clk);
      #1;
      op = nxt_op; funct3 = nxt_funct3; funct7b5 = nxt_f7b5;
      MemReady = mr; Zero = z; reset = rst;
      scb.push_back(model(st, mr, z, rst));
      @(negedge clk);
   endtask

   task automatic test_reset();
      set_instr(7'b0000000, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(F, 1'b0, 1'b0, (i < 2));
         got = obs; exp = scb.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset cycle %0d: got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic run_seq(input string name, input int sts[$], input bit mrs[$], input bit z);
      for (int i = 0; i < sts.size(); i++) begin
         drive(sts[i], mrs[i], z, 1'b0);
         got = obs; exp = scb.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, i, got, exp);
         end
      end
   endtask

   task automatic test_lw();
      set_instr(C_LW, 3'b010, 1'b0);
      run_seq("lw", '{F, D, MA, MR, MWB}, '{1, 1, 1, 1, 1}, 1'b0);
   endtask

   task automatic test_lw_wait();
      set_instr(C_LW, 3'b010, 1'b1);
      run_seq("lw_wait", '{F, D, MA, MR, MR, MR, MWB}, '{1, 1, 1, 0, 0, 1, 1}, 1'b0);
   endtask

   task automatic test_sw();
      set_instr(C_SW, 3'b010, 1'b0);
      run_seq("sw", '{F, D, MA, MW}, '{1, 1, 1, 1}, 1'b0);
   endtask

   task automatic test_alu_ops();
      set_instr(C_R, 3'b000, 1'b1);
      run_seq("r_sub", '{F, D, ER, AW}, '{1, 1, 1, 1}, 1'b0);
      set_instr(C_I, 3'b000, 1'b1);
      run_seq("addi_f7", '{F, D, EI, AW}, '{1, 1, 1, 1}, 1'b0);
      set_instr(C_R, 3'b010, 1'b0);
      run_seq("r_slt", '{F, D, ER, AW}, '{1, 1, 1, 1}, 1'b0);
      set_instr(C_R, 3'b110, 1'b0);
      run_seq("r_or", '{F, D, ER, AW}, '{1, 1, 1, 1}, 1'b0);
      set_instr(C_I, 3'b111, 1'b0);
      run_seq("andi", '{F, D, EI, AW}, '{1, 1, 1, 1}, 1'b0);
      set_instr(C_R, 3'b001, 1'b0);
      run_seq("r_other", '{F, D, ER, AW}, '{1, 1, 1, 1}, 1'b0);
   endtask

   task automatic test_branch_jump();
      set_instr(C_BEQ, 3'b000, 1'b0);
      run_seq("beq_taken", '{F, D, BQ}, '{1, 1, 1}, 1'b1);
      run_seq("beq_not", '{F, D, BQ}, '{1, 1, 1}, 1'b0);
      set_instr(C_JAL, 3'b000, 1'b0);
      run_seq("jal", '{F, D, J, AW}, '{1, 1, 1, 1}, 1'b0);
   endtask

   task automatic test_fetch_wait();
      set_instr(C_BEQ, 3'b000, 1'b0);
      run_seq("fetch_wait", '{F, F, F, F, D, BQ}, '{0, 0, 0, 1, 1, 1}, 1'b0);
   endtask

   task automatic test_illegal();
      set_instr(7'b1111111, 3'b000, 1'b1);
      run_seq("illegal", '{F, D, F, D}, '{1, 1, 1, 1}, 1'b0);
   endtask

   task automatic test_reset_midwrite();
      int sts[7];
      bit mrs[7];
      bit rsts[7];
      sts  = '{F, D, MA, MW, MW, MW, F};
      mrs  = '{1, 1, 1, 0, 0, 0, 0};
      rsts = '{0, 0, 0, 0, 0, 1, 0};
      set_instr(C_SW, 3'b010, 1'b0);
      for (int i = 0; i < 7; i++) begin
         drive(sts[i], mrs[i], 1'b0, rsts[i]);
         got = obs; exp = scb.pop_front(); checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_midwrite cycle %0d: got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      set_instr(C_I, 3'b110, 1'b0);
      run_seq("b2b_ori", '{F, D, EI, AW}, '{1, 1, 1, 1}, 1'b0);
      set_instr(C_LW, 3'b010, 1'b0);
      run_seq("b2b_lw", '{F, D, MA, MR, MWB}, '{1, 1, 1, 1, 1}, 1'b0);
      set_instr(C_SW, 3'b010, 1'b0);
      run_seq("b2b_sw_wait", '{F, F, D, MA, MW, MW}, '{0, 1, 1, 1, 0, 1}, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
      Zero = 1'b0; MemReady = 1'b0;
      nxt_op = 7'b0; nxt_funct3 = 3'b0; nxt_f7b5 = 1'b0;
      test_reset();
      test_lw();
      test_lw_wait();
      test_sw();
      test_alu_ops();
      test_branch_jump();
      test_fetch_wait();
      test_illegal();
      test_reset_midwrite();
      test_back_to_back();
      if (scb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", scb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
